// File: rtl/dma_burst_streamer_if.sv
// dma_burst_streamer_if
// Groups the descriptor channel and the burst request channel of the
// DMA burst streamer into one bundle.
//
// Descriptor channel (producer -> streamer):
//   desc_valid_i / desc_ready_o  handshake
//   desc_addr_i                  start byte address
//   desc_bytes_i                 transfer length in bytes
//   desc_mode_i                  1 = INCR, 0 = FIXED
// Request channel (streamer -> AXI interface block):
//   req_valid_o / req_ready_i    handshake
//   req_addr_o                   beat-aligned burst address
//   req_alen_o                   beats - 1
//   req_size_o                   log2(bytes per beat)
//   req_strb_o                   byte mask applied to every beat
//   req_mode_o                   copy of the descriptor mode
//
// Modports: master = the streamer itself, slave = whoever surrounds it.
interface dma_burst_streamer_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BYTES_WIDTH = 32
);
  localparam int BPB = DATA_WIDTH / 8;

  logic                   desc_valid_i;
  logic                   desc_ready_o;
  logic [ADDR_WIDTH-1:0]  desc_addr_i;
  logic [BYTES_WIDTH-1:0] desc_bytes_i;
  logic                   desc_mode_i;

  logic                   req_valid_o;
  logic                   req_ready_i;
  logic [ADDR_WIDTH-1:0]  req_addr_o;
  logic [7:0]             req_alen_o;
  logic [2:0]             req_size_o;
  logic [BPB-1:0]         req_strb_o;
  logic                   req_mode_o;

  modport master (
    input  desc_valid_i, desc_addr_i, desc_bytes_i, desc_mode_i, req_ready_i,
    output desc_ready_o, req_valid_o, req_addr_o, req_alen_o, req_size_o,
           req_strb_o, req_mode_o
  );

  modport slave (
    output desc_valid_i, desc_addr_i, desc_bytes_i, desc_mode_i, req_ready_i,
    input  desc_ready_o, req_valid_o, req_addr_o, req_alen_o, req_size_o,
           req_strb_o, req_mode_o
  );
endinterface

// File: rtl/dma_burst_streamer.sv
// dma_burst_streamer
// Takes one transfer descriptor (start address, byte count, mode) and
// splits it into AXI-legal burst requests: unaligned head and tail bytes
// become single-beat bursts with a partial strobe, full bursts are capped
// by MAX_BEATS (16 in FIXED mode) and, in INCR mode, by the 4 KB page.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   bus         dma_burst_streamer_if.master (descriptor + request channels)
//   abort_i     stop issuing bursts; the request on offer still completes
//   busy_o      descriptor in progress
//   done_o      one-cycle pulse at descriptor end
//   bursts_o    request handshakes of the current descriptor
//
// Optional feature macro: DMA_STREAMER_PERF_EN
//   defined   -> bursts_o is a saturating 16-bit handshake counter
//   undefined -> bursts_o is tied to zero
module dma_burst_streamer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_BEATS   = 256,
  parameter int BYTES_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  dma_burst_streamer_if.master bus,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          bursts_o
);
  localparam int BPB       = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(BPB);
  localparam int FIXED_CAP = (MAX_BEATS < 16) ? MAX_BEATS : 16;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_REQ, S_DONE} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]  cur_addr_q;
  logic [BYTES_WIDTH-1:0] rem_q;
  logic                   mode_q;
  logic                   abort_q;
  logic [BYTES_WIDTH-1:0] take_q;

  logic [ADDR_WIDTH-1:0]  req_addr_q;
  logic [7:0]             req_alen_q;
  logic [2:0]             req_size_q;
  logic [BPB-1:0]         req_strb_q;
  logic                   req_mode_q;

  logic                   desc_fire;
  logic                   req_fire;
  logic                   abort_seen;
  logic [BYTES_WIDTH-1:0] rem_after;

  logic [12:0]            off13;
  logic [12:0]            room13;
  logic [12:0]            kb_beats;
  logic [12:0]            len_cap;
  logic [12:0]            calc_beats;
  logic [12:0]            part_end;
  logic [BYTES_WIDTH-1:0] rem_beats;
  logic [BYTES_WIDTH-1:0] calc_take;
  logic                   calc_partial;
  logic [BPB-1:0]         calc_strb;
  logic [7:0]             calc_alen;

  assign desc_fire  = (state_q == S_IDLE) && bus.desc_valid_i;
  assign req_fire   = (state_q == S_REQ) && bus.req_ready_i;
  assign abort_seen = abort_q | abort_i;
  assign rem_after  = rem_q - take_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An abort seen while a request is on offer does not
  // withdraw it; the FSM only leaves REQ on the handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (desc_fire) begin
          state_d = (bus.desc_bytes_i == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        state_d = abort_seen ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (req_fire) begin
          state_d = ((rem_after == '0) || abort_seen) ? S_DONE : S_CALC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status and request-channel outputs. Request fields come straight from
  // registers loaded in CALC, so they cannot move while REQ waits.
  always_comb begin
    bus.desc_ready_o = (state_q == S_IDLE);
    bus.req_valid_o  = (state_q == S_REQ);
    busy_o           = (state_q != S_IDLE);
    done_o           = (state_q == S_DONE);
    bus.req_addr_o   = req_addr_q;
    bus.req_alen_o   = req_alen_q;
    bus.req_size_o   = req_size_q;
    bus.req_strb_o   = req_strb_q;
    bus.req_mode_o   = req_mode_q;
  end

  // Burst sizing for the current address and remaining byte count.
  // Head (unaligned) and tail (less than one beat) bursts are single beats
  // with a partial strobe; everything else is a full-strobe burst limited
  // by the remaining whole beats, the burst cap and, in INCR mode, the
  // distance to the next 4 KB page.
  always_comb begin
    off13        = 13'(cur_addr_q[OFF_W-1:0]);
    room13       = 13'(BPB) - off13;
    rem_beats    = rem_q >> OFF_W;
    kb_beats     = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> OFF_W;
    len_cap      = mode_q ? 13'(MAX_BEATS) : 13'(FIXED_CAP);
    calc_beats   = 13'd1;
    calc_take    = '0;
    calc_partial = 1'b1;
    if (off13 != 13'd0) begin
      calc_take = (rem_q < BYTES_WIDTH'(room13)) ? rem_q : BYTES_WIDTH'(room13);
    end else if (rem_q < BYTES_WIDTH'(BPB)) begin
      calc_take = rem_q;
    end else begin
      calc_partial = 1'b0;
      calc_beats   = len_cap;
      if (rem_beats < BYTES_WIDTH'(calc_beats)) begin
        calc_beats = 13'(rem_beats);
      end
      if (mode_q && (kb_beats < calc_beats)) begin
        calc_beats = kb_beats;
      end
      calc_take = BYTES_WIDTH'(calc_beats) << OFF_W;
    end
    calc_alen = 8'(calc_beats - 13'd1);
    part_end  = off13 + 13'(calc_take);
    calc_strb = '0;
    for (int i = 0; i < BPB; i++) begin
      calc_strb[i] = !calc_partial || ((13'(i) >= off13) && (13'(i) < part_end));
    end
  end

  // Descriptor, progress and request registers. The address only advances
  // in INCR mode; FIXED transfers keep hitting the same location.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q <= '0;
      rem_q      <= '0;
      mode_q     <= 1'b0;
      take_q     <= '0;
      req_addr_q <= '0;
      req_alen_q <= '0;
      req_size_q <= '0;
      req_strb_q <= '0;
      req_mode_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (desc_fire) begin
            cur_addr_q <= bus.desc_addr_i;
            rem_q      <= bus.desc_bytes_i;
            mode_q     <= bus.desc_mode_i;
          end
        end
        S_CALC: begin
          req_addr_q <= {cur_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          req_alen_q <= calc_alen;
          req_size_q <= 3'(OFF_W);
          req_strb_q <= calc_strb;
          req_mode_q <= mode_q;
          take_q     <= calc_take;
        end
        S_REQ: begin
          if (req_fire) begin
            rem_q <= rem_after;
            if (mode_q) begin
              cur_addr_q <= cur_addr_q + ADDR_WIDTH'(take_q);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky abort: ignored while idle, cleared when the descriptor finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      abort_q <= 1'b0;
    end else if ((state_q == S_IDLE) || (state_q == S_DONE)) begin
      abort_q <= 1'b0;
    end else if (abort_i) begin
      abort_q <= 1'b1;
    end
  end

  // A burst must never consume more bytes than remain.
  assert property (@(posedge clk) disable iff (rst) req_fire |-> (take_q <= rem_q));

`ifdef DMA_STREAMER_PERF_EN
  logic [15:0] bursts_q;

  // Per-descriptor handshake counter; cleared on acceptance, saturating,
  // and left alone after done so software can read it back.
  always_ff @(posedge clk) begin
    if (rst) begin
      bursts_q <= '0;
    end else if (desc_fire) begin
      bursts_q <= '0;
    end else if (req_fire && (bursts_q != 16'hFFFF)) begin
      bursts_q <= bursts_q + 16'd1;
    end
  end

  assign bursts_o = bursts_q;
`else
  assign bursts_o = 16'd0;
`endif

endmodule

// File: tb/tb_dma_burst_streamer.sv
// tb_dma_burst_streamer
// Directed bench for dma_burst_streamer (DATA_WIDTH 32, MAX_BEATS 256).
// Each scenario task drives its own descriptor and compares the observed
// burst requests against hand-computed values. Timing is expressed as the
// number of cycles after the descriptor acceptance cycle (t = 1 is CALC).
`timescale 1ns/1ps
module tb_dma_burst_streamer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 32;
  localparam int MB = 256;

`ifdef DMA_STREAMER_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [15:0] bursts_o;

  dma_burst_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTES_WIDTH(BW)) bus ();

  dma_burst_streamer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(MB), .BYTES_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .bursts_o(bursts_o)
  );

  // Free-running clock and cycle counter used for relative timing.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_addr [8];
  logic [7:0]  cap_alen [8];
  logic [3:0]  cap_strb [8];
  logic [2:0]  cap_size [8];
  logic        cap_mode [8];
  int          cap_t    [8];
  int          n_req, first_valid_t, done_t;
  bit          timed_out;
  logic        done_after;

  function automatic logic [15:0] exp_bursts(input int n);
    return PERF ? 16'(n) : 16'd0;
  endfunction

  // Sends one descriptor and records every request handshake until done_o.
  task automatic run_transfer(input logic [31:0] a, input logic [31:0] b,
                              input logic m, input bit abort_calc);
    int acc;
    int t;
    n_req = 0; first_valid_t = -1; done_t = -1; timed_out = 0; done_after = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cap_addr[i] = '1; cap_alen[i] = '1; cap_strb[i] = '1; cap_size[i] = '1;
      cap_mode[i] = 1'bx; cap_t[i] = -1;
    end
    @(negedge clk);
    bus.desc_addr_i = a; bus.desc_bytes_i = b; bus.desc_mode_i = m; bus.desc_valid_i = 1'b1;
    t = 0;
    while (!bus.desc_ready_o && t < 100) begin @(negedge clk); t++; end
    acc = cyc;
    @(posedge clk); #1;
    bus.desc_valid_i = 1'b0;
    abort_i = abort_calc;
    while (done_t < 0 && !timed_out) begin
      @(negedge clk);
      t = cyc - acc;
      if (t == 2) abort_i = 1'b0;
      if (bus.req_valid_o) begin
        if (first_valid_t < 0) first_valid_t = t;
        if (bus.req_ready_i) begin
          if (n_req < 8) begin
            cap_addr[n_req] = bus.req_addr_o; cap_alen[n_req] = bus.req_alen_o;
            cap_strb[n_req] = bus.req_strb_o; cap_size[n_req] = bus.req_size_o;
            cap_mode[n_req] = bus.req_mode_o; cap_t[n_req] = t;
          end
          n_req++;
        end
      end
      if (done_o) done_t = t;
      if (t > 3000) timed_out = 1;
    end
    @(negedge clk);
    done_after = done_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.desc_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset desc_ready: got %b expected 1", bus.desc_ready_o); end
    checks++; if ({bus.req_valid_o, busy_o, done_o} !== 3'b000) begin errors++; $display("[TB] FAIL reset valid/busy/done: got %b expected 000", {bus.req_valid_o, busy_o, done_o}); end
    checks++; if ({bus.req_addr_o, bus.req_alen_o, bus.req_size_o, bus.req_strb_o, bus.req_mode_o} !== '0) begin errors++; $display("[TB] FAIL reset req fields: got %h/%h/%h/%h/%b expected all 0", bus.req_addr_o, bus.req_alen_o, bus.req_size_o, bus.req_strb_o, bus.req_mode_o); end
    checks++; if (bursts_o !== 16'd0) begin errors++; $display("[TB] FAIL reset bursts: got %0d expected 0", bursts_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aligned_incr();
    run_transfer(32'h1000, 32'd64, 1'b1, 1'b0);
    checks++; if (n_req !== 1) begin errors++; $display("[TB] FAIL aligned n_req: got %0d expected 1", n_req); end
    checks++; if (cap_addr[0] !== 32'h1000 || cap_alen[0] !== 8'd15) begin errors++; $display("[TB] FAIL aligned addr/alen: got %h/%0d expected 1000/15", cap_addr[0], cap_alen[0]); end
    checks++; if (cap_size[0] !== 3'd2 || cap_strb[0] !== 4'hF || cap_mode[0] !== 1'b1) begin errors++; $display("[TB] FAIL aligned size/strb/mode: got %0d/%h/%b expected 2/f/1", cap_size[0], cap_strb[0], cap_mode[0]); end
    checks++; if (first_valid_t !== 2) begin errors++; $display("[TB] FAIL aligned first valid: got t=%0d expected t=2", first_valid_t); end
    checks++; if (done_t !== 3) begin errors++; $display("[TB] FAIL aligned done time: got t=%0d expected t=3", done_t); end
    checks++; if (done_after !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL aligned done pulse width/busy: got %b/%b expected 0/0", done_after, busy_o); end
    checks++; if (bursts_o !== exp_bursts(1)) begin errors++; $display("[TB] FAIL aligned bursts: got %0d expected %0d", bursts_o, exp_bursts(1)); end
  endtask

  // Abort is held high while idle; it must not affect the transfer.
  task automatic test_unaligned();
    abort_i = 1'b1;
    repeat (3) @(negedge clk);
    run_transfer(32'h1002, 32'd8, 1'b1, 1'b0);
    checks++; if (n_req !== 3) begin errors++; $display("[TB] FAIL unaligned n_req: got %0d expected 3", n_req); end
    checks++; if ({cap_addr[0], cap_strb[0], cap_alen[0]} !== {32'h1000, 4'hC, 8'd0}) begin errors++; $display("[TB] FAIL unaligned head: got %h/%h/%0d expected 1000/c/0", cap_addr[0], cap_strb[0], cap_alen[0]); end
    checks++; if ({cap_addr[1], cap_strb[1], cap_alen[1]} !== {32'h1004, 4'hF, 8'd0}) begin errors++; $display("[TB] FAIL unaligned body: got %h/%h/%0d expected 1004/f/0", cap_addr[1], cap_strb[1], cap_alen[1]); end
    checks++; if ({cap_addr[2], cap_strb[2], cap_alen[2]} !== {32'h1008, 4'h3, 8'd0}) begin errors++; $display("[TB] FAIL unaligned tail: got %h/%h/%0d expected 1008/3/0", cap_addr[2], cap_strb[2], cap_alen[2]); end
    checks++; if (cap_t[1] !== 4 || cap_t[2] !== 6 || done_t !== 7) begin errors++; $display("[TB] FAIL unaligned timing: got %0d/%0d/%0d expected 4/6/7", cap_t[1], cap_t[2], done_t); end
    checks++; if (bursts_o !== exp_bursts(3)) begin errors++; $display("[TB] FAIL unaligned bursts: got %0d expected %0d", bursts_o, exp_bursts(3)); end
  endtask

  task automatic test_4k_cross();
    run_transfer(32'h0FF0, 32'd64, 1'b1, 1'b0);
    checks++; if (n_req !== 2) begin errors++; $display("[TB] FAIL 4k n_req: got %0d expected 2", n_req); end
    checks++; if ({cap_addr[0], cap_alen[0], cap_strb[0]} !== {32'h0FF0, 8'd3, 4'hF}) begin errors++; $display("[TB] FAIL 4k first: got %h/%0d/%h expected ff0/3/f", cap_addr[0], cap_alen[0], cap_strb[0]); end
    checks++; if ({cap_addr[1], cap_alen[1], cap_strb[1]} !== {32'h1000, 8'd11, 4'hF}) begin errors++; $display("[TB] FAIL 4k second: got %h/%0d/%h expected 1000/11/f", cap_addr[1], cap_alen[1], cap_strb[1]); end
    checks++; if (done_t !== 5) begin errors++; $display("[TB] FAIL 4k done time: got t=%0d expected t=5", done_t); end
  endtask

  task automatic test_max_burst();
    run_transfer(32'h0, 32'd2048, 1'b1, 1'b0);
    checks++; if (n_req !== 2) begin errors++; $display("[TB] FAIL max n_req: got %0d expected 2", n_req); end
    checks++; if ({cap_addr[0], cap_alen[0]} !== {32'h0, 8'd255}) begin errors++; $display("[TB] FAIL max first: got %h/%0d expected 0/255", cap_addr[0], cap_alen[0]); end
    checks++; if ({cap_addr[1], cap_alen[1]} !== {32'h400, 8'd255}) begin errors++; $display("[TB] FAIL max second: got %h/%0d expected 400/255", cap_addr[1], cap_alen[1]); end
  endtask

  task automatic test_fixed();
    run_transfer(32'h40, 32'd128, 1'b0, 1'b0);
    checks++; if (n_req !== 2) begin errors++; $display("[TB] FAIL fixed n_req: got %0d expected 2", n_req); end
    checks++; if ({cap_addr[0], cap_alen[0], cap_mode[0]} !== {32'h40, 8'd15, 1'b0}) begin errors++; $display("[TB] FAIL fixed first: got %h/%0d/%b expected 40/15/0", cap_addr[0], cap_alen[0], cap_mode[0]); end
    checks++; if ({cap_addr[1], cap_alen[1], cap_mode[1]} !== {32'h40, 8'd15, 1'b0}) begin errors++; $display("[TB] FAIL fixed second: got %h/%0d/%b expected 40/15/0", cap_addr[1], cap_alen[1], cap_mode[1]); end
  endtask

  // Two-burst descriptor stalled on its first request; the abort pulse
  // must suppress the second burst but not the one already on offer.
  task automatic test_backpressure_abort();
    int t;
    bus.req_ready_i = 1'b0;
    @(negedge clk);
    bus.desc_addr_i = 32'h0FF0; bus.desc_bytes_i = 32'd64; bus.desc_mode_i = 1'b1; bus.desc_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.desc_valid_i = 1'b0;
    t = 0;
    while (!bus.req_valid_o && t < 20) begin @(negedge clk); t++; end
    checks++; if (bus.req_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL stall valid: got %b expected 1", bus.req_valid_o); end
    for (int k = 0; k < 5; k++) begin
      abort_i = (k == 1);
      @(negedge clk);
      checks++; if ({bus.req_valid_o, bus.req_addr_o, bus.req_alen_o, bus.req_strb_o, bus.desc_ready_o} !== {1'b1, 32'h0FF0, 8'd3, 4'hF, 1'b0}) begin
        errors++; $display("[TB] FAIL stall hold %0d: got %b/%h/%0d/%h/%b expected 1/ff0/3/f/0", k, bus.req_valid_o, bus.req_addr_o, bus.req_alen_o, bus.req_strb_o, bus.desc_ready_o);
      end
    end
    abort_i = 1'b0;
    bus.req_ready_i = 1'b1;
    @(negedge clk);
    checks++; if ({done_o, bus.req_valid_o} !== 2'b10) begin errors++; $display("[TB] FAIL abort done: got done/valid %b expected 10", {done_o, bus.req_valid_o}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({done_o, bus.req_valid_o, busy_o} !== 3'b000) begin errors++; $display("[TB] FAIL abort quiet %0d: got done/valid/busy %b expected 000", k, {done_o, bus.req_valid_o, busy_o}); end
    end
    checks++; if (bursts_o !== exp_bursts(1)) begin errors++; $display("[TB] FAIL abort bursts: got %0d expected %0d", bursts_o, exp_bursts(1)); end
  endtask

  task automatic test_abort_calc();
    run_transfer(32'h2000, 32'd32, 1'b1, 1'b1);
    checks++; if (first_valid_t !== -1 || n_req !== 0) begin errors++; $display("[TB] FAIL calc abort issued: got first valid t=%0d n_req=%0d expected none", first_valid_t, n_req); end
    checks++; if (done_t !== 2) begin errors++; $display("[TB] FAIL calc abort done: got t=%0d expected t=2", done_t); end
  endtask

  task automatic test_zero_bytes();
    run_transfer(32'h3000, 32'd0, 1'b1, 1'b0);
    checks++; if (first_valid_t !== -1) begin errors++; $display("[TB] FAIL zero valid seen: got t=%0d expected none", first_valid_t); end
    checks++; if (done_t !== 1) begin errors++; $display("[TB] FAIL zero done: got t=%0d expected t=1", done_t); end
    checks++; if (bursts_o !== exp_bursts(0)) begin errors++; $display("[TB] FAIL zero bursts: got %0d expected %0d", bursts_o, exp_bursts(0)); end
  endtask

  task automatic test_small_unaligned();
    run_transfer(32'h1001, 32'd2, 1'b1, 1'b0);
    checks++; if (n_req !== 1) begin errors++; $display("[TB] FAIL small n_req: got %0d expected 1", n_req); end
    checks++; if ({cap_addr[0], cap_alen[0], cap_strb[0]} !== {32'h1000, 8'd0, 4'h6}) begin errors++; $display("[TB] FAIL small req: got %h/%0d/%h expected 1000/0/6", cap_addr[0], cap_alen[0], cap_strb[0]); end
    checks++; if (done_t !== 3) begin errors++; $display("[TB] FAIL small done: got t=%0d expected t=3", done_t); end
  endtask

  task automatic test_rst_mid();
    int t;
    bus.req_ready_i = 1'b0;
    @(negedge clk);
    bus.desc_addr_i = 32'h1000; bus.desc_bytes_i = 32'd64; bus.desc_mode_i = 1'b1; bus.desc_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.desc_valid_i = 1'b0;
    t = 0;
    while (!bus.req_valid_o && t < 20) begin @(negedge clk); t++; end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.desc_ready_o, bus.req_valid_o, busy_o, done_o} !== 4'b1000) begin errors++; $display("[TB] FAIL rst mid status: got %b expected 1000", {bus.desc_ready_o, bus.req_valid_o, busy_o, done_o}); end
    checks++; if ({bus.req_addr_o, bus.req_alen_o, bus.req_strb_o, bursts_o} !== '0) begin errors++; $display("[TB] FAIL rst mid fields: got %h/%0d/%h/%0d expected 0", bus.req_addr_o, bus.req_alen_o, bus.req_strb_o, bursts_o); end
    rst = 1'b0;
    bus.req_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({done_o, bus.req_valid_o} !== 2'b00) begin errors++; $display("[TB] FAIL rst mid quiet %0d: got done/valid %b expected 00", k, {done_o, bus.req_valid_o}); end
    end
  endtask

  // Scenario sequence.
  initial begin
    bus.desc_valid_i = 1'b0;
    bus.desc_addr_i  = '0;
    bus.desc_bytes_i = '0;
    bus.desc_mode_i  = 1'b0;
    bus.req_ready_i  = 1'b1;
    test_reset();
    test_aligned_incr();
    test_unaligned();
    test_4k_cross();
    test_max_burst();
    test_fixed();
    test_backpressure_abort();
    test_abort_calc();
    test_zero_bytes();
    test_small_unaligned();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Global time limit in case a scenario stalls outside its own bounds.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test expected completion within 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
